// File: rtl/armleocpu_ptw_pkg.sv
// rtl/armleocpu_ptw_pkg.sv - Sv32 page-table walker states, PTE field positions and bus constants
package armleocpu_ptw_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } ptw_state_t;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  localparam int PPN1_HI = 31;
  localparam int PPN1_LO = 20;
  localparam int PPN0_HI = 19;
  localparam int PPN0_LO = 10;

  localparam logic [1:0] AVL_OK           = 2'b00;
  localparam logic [7:0] BARE_ACCESS_BITS = 8'hCF;

  // Byte address of a 4-byte PTE inside a 4 KiB table.
  function automatic logic [33:0] pte_address(input logic [21:0] table_ppn, input logic [9:0] index);
    return {table_ppn, index, 2'b00};
  endfunction

endpackage

// File: rtl/armleocpu_ptw.sv
// rtl/armleocpu_ptw.sv - Sv32 page-table walker with an Avalon-MM read master
// Define ARMLEOCPU_PTW_AD_CHECK_EN to raise a page fault on leaf PTEs whose A bit is clear.
module armleocpu_ptw
  import armleocpu_ptw_pkg::*;
(
  input  logic        clk,
  input  logic        async_rst,
  input  logic        matp_mode,
  input  logic [21:0] matp_ppn,
  input  logic        resolve_request,
  input  logic [19:0] virtual_address,
  output logic        resolve_ack,
  output logic        resolve_done,
  output logic        resolve_pagefault,
  output logic        resolve_accessfault,
  output logic [7:0]  resolve_access_bits,
  output logic [21:0] resolve_physical_address,
  output logic [33:0] avl_address,
  output logic        avl_read,
  input  logic        avl_waitrequest,
  input  logic        avl_readdatavalid,
  input  logic [31:0] avl_readdata,
  input  logic [1:0]  avl_response,
  output logic [24:0] state_debug_output
);

  ptw_state_t  state;
  logic        level;
  logic [19:0] vpn;
  logic [21:0] table_ppn;
  logic [1:0]  last_response;

  logic [21:0] res_ppn;
  logic [7:0]  res_bits;
  logic        res_pagefault;
  logic        res_accessfault;

  logic pte_invalid;
  logic pte_leaf;
  logic pte_misaligned;
  logic pte_ad_fault;
  logic unused_rsw;

  always_comb begin
    pte_invalid    = !avl_readdata[PTE_V] || (!avl_readdata[PTE_R] && avl_readdata[PTE_W]);
    pte_leaf       = avl_readdata[PTE_R] || avl_readdata[PTE_X];
    pte_misaligned = level && (avl_readdata[PPN0_HI:PPN0_LO] != 10'd0);
  end

`ifdef ARMLEOCPU_PTW_AD_CHECK_EN
  assign pte_ad_fault = !avl_readdata[PTE_A];
`else
  assign pte_ad_fault = 1'b0;
`endif

  // RSW bits are software-defined and never affect the walk.
  assign unused_rsw = ^avl_readdata[9:8];

  assign state_debug_output = {last_response, vpn, level, state};

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state                    <= IDLE;
      level                    <= 1'b1;
      vpn                      <= '0;
      table_ppn                <= '0;
      last_response            <= AVL_OK;
      res_ppn                  <= '0;
      res_bits                 <= '0;
      res_pagefault            <= 1'b0;
      res_accessfault          <= 1'b0;
      avl_read                 <= 1'b0;
      avl_address              <= '0;
      resolve_ack              <= 1'b0;
      resolve_done             <= 1'b0;
      resolve_pagefault        <= 1'b0;
      resolve_accessfault      <= 1'b0;
      resolve_access_bits      <= '0;
      resolve_physical_address <= '0;
    end else begin
      resolve_ack  <= 1'b0;
      resolve_done <= 1'b0;
      case (state)
        IDLE: begin
          if (resolve_request) begin
            vpn         <= virtual_address;
            resolve_ack <= 1'b1;
            if (matp_mode) begin
              level       <= 1'b1;
              table_ppn   <= matp_ppn;
              avl_read    <= 1'b1;
              avl_address <= pte_address(matp_ppn, virtual_address[19:10]);
              state       <= ISSUE;
            end else begin
              res_ppn         <= {2'b00, virtual_address};
              res_bits        <= BARE_ACCESS_BITS;
              res_pagefault   <= 1'b0;
              res_accessfault <= 1'b0;
              state           <= DONE;
            end
          end
        end
        ISSUE: begin
          if (!avl_waitrequest) begin
            avl_read <= 1'b0;
            state    <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (avl_readdatavalid) begin
            last_response   <= avl_response;
            res_ppn         <= '0;
            res_bits        <= '0;
            res_pagefault   <= 1'b0;
            res_accessfault <= 1'b0;
            state           <= DONE;
            // Bus errors win over anything decoded from the returned word.
            if (avl_response != AVL_OK) begin
              res_accessfault <= 1'b1;
            end else if (pte_invalid) begin
              res_pagefault <= 1'b1;
            end else if (pte_leaf) begin
              if (pte_misaligned || pte_ad_fault) begin
                res_pagefault <= 1'b1;
              end else begin
                res_ppn  <= level ? {avl_readdata[PPN1_HI:PPN1_LO], vpn[9:0]}
                                  : avl_readdata[PPN1_HI:PPN0_LO];
                res_bits <= avl_readdata[7:0];
              end
            end else if (level) begin
              level       <= 1'b0;
              table_ppn   <= avl_readdata[PPN1_HI:PPN0_LO];
              avl_read    <= 1'b1;
              avl_address <= pte_address(avl_readdata[PPN1_HI:PPN0_LO], vpn[9:0]);
              state       <= ISSUE;
            end else begin
              res_pagefault <= 1'b1;
            end
          end
        end
        DONE: begin
          resolve_done             <= 1'b1;
          resolve_pagefault        <= res_pagefault;
          resolve_accessfault      <= res_accessfault;
          resolve_access_bits      <= res_bits;
          resolve_physical_address <= res_ppn;
          state                    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_ptw.sv
// tb/tb_armleocpu_ptw.sv - self-checking bench for armleocpu_ptw
module tb_armleocpu_ptw;

  logic        clk = 1'b0;
  logic        async_rst;
  logic        matp_mode;
  logic [21:0] matp_ppn;
  logic        resolve_request;
  logic [19:0] virtual_address;
  logic        resolve_ack;
  logic        resolve_done;
  logic        resolve_pagefault;
  logic        resolve_accessfault;
  logic [7:0]  resolve_access_bits;
  logic [21:0] resolve_physical_address;
  logic [33:0] avl_address;
  logic        avl_read;
  logic        avl_waitrequest;
  logic        avl_readdatavalid;
  logic [31:0] avl_readdata;
  logic [1:0]  avl_response;
  logic [24:0] state_debug_output;

  always #5 clk = ~clk;

`ifdef ARMLEOCPU_PTW_AD_CHECK_EN
  localparam bit AD_CHECK = 1'b1;
`else
  localparam bit AD_CHECK = 1'b0;
`endif

  armleocpu_ptw dut (
    .clk(clk),
    .async_rst(async_rst),
    .matp_mode(matp_mode),
    .matp_ppn(matp_ppn),
    .resolve_request(resolve_request),
    .virtual_address(virtual_address),
    .resolve_ack(resolve_ack),
    .resolve_done(resolve_done),
    .resolve_pagefault(resolve_pagefault),
    .resolve_accessfault(resolve_accessfault),
    .resolve_access_bits(resolve_access_bits),
    .resolve_physical_address(resolve_physical_address),
    .avl_address(avl_address),
    .avl_read(avl_read),
    .avl_waitrequest(avl_waitrequest),
    .avl_readdatavalid(avl_readdatavalid),
    .avl_readdata(avl_readdata),
    .avl_response(avl_response),
    .state_debug_output(state_debug_output)
  );

  typedef struct {
    string       name;
    bit          mode;
    logic [19:0] vpn;
    logic [31:0] pte1;
    logic [1:0]  rsp1;
    logic [31:0] pte0;
    logic [1:0]  rsp0;
    bit          pf;
    bit          af;
    logic [21:0] ppn;
    logic [7:0]  bits;
    int          nreads;
    logic [33:0] a1;
    logic [33:0] a2;
  } vec_t;

  vec_t vecs[17];

  int checks = 0;
  int errors = 0;

  // Word-indexed memory: {response, pte}; absent words read as an OKAY zero PTE.
  logic [33:0] mem [longint];
  logic [33:0] read_log[$];
  logic [33:0] stall_addrs[$];
  int          stall_left = 0;
  bit          pending = 1'b0;
  logic [33:0] pend_word;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [33:0] mem_rd(input longint key);
    if (mem.exists(key)) return mem[key];
    return 34'h0;
  endfunction

  function automatic bit bit_of(input longint v, input int i);
    return ((v >> i) & 1) == 1;
  endfunction

  // Reference walk straight from the Sv32 rules, using byte arithmetic on the memory array.
  function automatic void ref_walk(input bit mode, input longint root, input longint va,
                                   output bit pf, output bit af, output longint ppn, output longint bits,
                                   output int nreads, output longint a1, output longint a2);
    longint tbl, idx, addr, pte;
    logic [33:0] w;
    pf = 0; af = 0; ppn = 0; bits = 0; nreads = 0; a1 = 0; a2 = 0;
    if (!mode) begin
      ppn = va;
      bits = 'hCF;
      return;
    end
    tbl = root;
    for (int lvl = 1; lvl >= 0; lvl--) begin
      idx = (lvl == 1) ? va / 1024 : va % 1024;
      addr = tbl * 4096 + idx * 4;
      if (nreads == 0) a1 = addr; else a2 = addr;
      nreads++;
      w = mem_rd(addr / 4);
      pte = longint'(w[31:0]);
      if (w[33:32] != 2'b00) begin af = 1; return; end
      if (!bit_of(pte, 0) || (!bit_of(pte, 1) && bit_of(pte, 2))) begin pf = 1; return; end
      if (bit_of(pte, 1) || bit_of(pte, 3)) begin
        if (lvl == 1 && ((pte >> 10) % 1024) != 0) begin pf = 1; return; end
        if (AD_CHECK && !bit_of(pte, 6)) begin pf = 1; return; end
        ppn = (lvl == 1) ? (pte >> 20) * 1024 + va % 1024 : pte >> 10;
        bits = pte % 256;
        return;
      end
      if (lvl == 0) begin pf = 1; return; end
      tbl = pte >> 10;
    end
  endfunction

  function automatic logic [31:0] rand_pte(input bit lvl1);
    logic [31:0] p;
    p = $urandom;
    case ($urandom_range(0, 4))
      0: p[7:0] = 8'h01;
      1: begin p[0] = 1'b1; p[1] = 1'b1; if (lvl1) p[19:10] = 10'd0; end
      2: begin p[3:0] = 4'b1001; if (lvl1) p[19:10] = 10'd0; end
      default: ;
    endcase
    return p;
  endfunction

  // Memory slave: one-cycle read latency, optional waitrequest on the first read of a walk.
  initial begin
    avl_waitrequest = 1'b0;
    avl_readdatavalid = 1'b0;
    avl_readdata = 32'h0;
    avl_response = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      avl_readdatavalid = 1'b0;
      if (async_rst) begin
        pending = 1'b0;
        avl_waitrequest = 1'b0;
      end else begin
        if (pending) begin
          {avl_response, avl_readdata} = pend_word;
          avl_readdatavalid = 1'b1;
          pending = 1'b0;
        end
        if (avl_read && stall_left > 0) begin
          avl_waitrequest = 1'b1;
          stall_left--;
          stall_addrs.push_back(avl_address);
        end else begin
          avl_waitrequest = 1'b0;
          if (avl_read) begin
            read_log.push_back(avl_address);
            pend_word = mem_rd(longint'(avl_address >> 2));
            pending = 1'b1;
          end
        end
      end
    end
  end

  task automatic start_walk(input bit mode, input logic [21:0] root, input logic [19:0] vpn, input int stall);
    int n;
    n = 0;
    read_log.delete();
    stall_addrs.delete();
    stall_left = stall;
    matp_mode = mode;
    matp_ppn = root;
    virtual_address = vpn;
    resolve_request = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!resolve_ack && n < 20);
    chk("ack", 64'(resolve_ack), 64'd1);
    virtual_address = 20'($urandom);
  endtask

  task automatic run_walk(input string tag, input bit mode, input logic [21:0] root, input logic [19:0] vpn,
                          input int stall, input bit e_pf, input bit e_af, input logic [21:0] e_ppn,
                          input logic [7:0] e_bits, input int e_nreads, input logic [33:0] e_a1, input logic [33:0] e_a2);
    int lat, acks, e_lat;
    lat = 0;
    acks = 0;
    e_lat = (e_nreads == 0) ? 1 : 2 * e_nreads + 1 + stall;
    start_walk(mode, root, vpn, stall);
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (resolve_ack) acks++;
    end while (!resolve_done && lat < 60);
    resolve_request = 1'b0;
    chk({tag, ".done"}, 64'(resolve_done), 64'd1);
    chk({tag, ".pagefault"}, 64'(resolve_pagefault), 64'(e_pf));
    chk({tag, ".accessfault"}, 64'(resolve_accessfault), 64'(e_af));
    chk({tag, ".ppn"}, 64'(resolve_physical_address), 64'(e_ppn));
    chk({tag, ".bits"}, 64'(resolve_access_bits), 64'(e_bits));
    chk({tag, ".latency"}, 64'(lat), 64'(e_lat));
    chk({tag, ".extra_ack"}, 64'(acks), 64'd0);
    chk({tag, ".nreads"}, 64'(read_log.size()), 64'(e_nreads));
    if (e_nreads > 0 && read_log.size() > 0) chk({tag, ".addr1"}, 64'(read_log[0]), 64'(e_a1));
    if (e_nreads > 1 && read_log.size() > 1) chk({tag, ".addr2"}, 64'(read_log[1]), 64'(e_a2));
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 64'(resolve_done), 64'd0);
    chk({tag, ".hold_ppn"}, 64'(resolve_physical_address), 64'(e_ppn));
  endtask

  initial begin
    int done_count;
    bit m_pf, m_af;
    longint m_ppn, m_bits, m_a1, m_a2;
    int m_n;

    async_rst = 1'b1;
    matp_mode = 1'b0;
    matp_ppn = 22'h0;
    resolve_request = 1'b0;
    virtual_address = 20'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.avl_read", 64'(avl_read), 64'd0);
    chk("rst.avl_address", 64'(avl_address), 64'd0);
    chk("rst.done", 64'(resolve_done), 64'd0);
    chk("rst.ack", 64'(resolve_ack), 64'd0);
    chk("rst.faults", 64'({resolve_pagefault, resolve_accessfault}), 64'd0);
    chk("rst.bits", 64'(resolve_access_bits), 64'd0);
    chk("rst.ppn", 64'(resolve_physical_address), 64'd0);
    chk("rst.state", 64'(state_debug_output[1:0]), 64'd0);
    chk("rst.level", 64'(state_debug_output[2]), 64'd1);
    async_rst = 1'b0;

    vecs[0]  = '{"af_l1",    1'b1, {10'd1, 10'd0}, 32'h0,         2'b11, 32'h0, 2'b00, 1'b0, 1'b1, 22'h0, 8'h00, 1, 34'h4, 34'h0};
    vecs[1]  = '{"misalign", 1'b1, {10'd3, 10'd0}, 32'h0040_040F, 2'b00, 32'h0, 2'b00, 1'b1, 1'b0, 22'h0, 8'h00, 1, 34'hC, 34'h0};
    vecs[2]  = '{"mega_rwx", 1'b1, {10'd3, 10'd5}, 32'h0010_000F, 2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 22'h000405, 8'h0F, 1, 34'hC, 34'h0};
    vecs[3]  = '{"mega_rw",  1'b1, {10'd3, 10'd5}, 32'h0010_0007, 2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 22'h000405, 8'h07, 1, 34'hC, 34'h0};
    vecs[4]  = '{"mega_rx",  1'b1, {10'd3, 10'd5}, 32'h0010_000B, 2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 22'h000405, 8'h0B, 1, 34'hC, 34'h0};
    vecs[5]  = '{"mega_r",   1'b1, {10'd3, 10'd5}, 32'h0010_0003, 2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 22'h000405, 8'h03, 1, 34'hC, 34'h0};
    vecs[6]  = '{"mega_x",   1'b1, {10'd3, 10'd5}, 32'h0010_0009, 2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 22'h000405, 8'h09, 1, 34'hC, 34'h0};
    vecs[7]  = '{"af_l0",    1'b1, {10'd2, 10'd7}, 32'h0000_0401, 2'b00, 32'h0, 2'b11, 1'b0, 1'b1, 22'h0, 8'h00, 2, 34'h8, 34'h101C};
    vecs[8]  = '{"l1_v0",    1'b1, {10'd4, 10'd0}, 32'h0,         2'b00, 32'h0, 2'b00, 1'b1, 1'b0, 22'h0, 8'h00, 1, 34'h10, 34'h0};
    vecs[9]  = '{"l1_w",     1'b1, {10'd4, 10'd0}, 32'h05,        2'b00, 32'h0, 2'b00, 1'b1, 1'b0, 22'h0, 8'h00, 1, 34'h10, 34'h0};
    vecs[10] = '{"l1_xw",    1'b1, {10'd4, 10'd0}, 32'h0D,        2'b00, 32'h0, 2'b00, 1'b1, 1'b0, 22'h0, 8'h00, 1, 34'h10, 34'h0};
    vecs[11] = '{"l0_v0",    1'b1, {10'd2, 10'd7}, 32'h0000_0401, 2'b00, 32'h0,  2'b00, 1'b1, 1'b0, 22'h0, 8'h00, 2, 34'h8, 34'h101C};
    vecs[12] = '{"l0_w",     1'b1, {10'd2, 10'd7}, 32'h0000_0401, 2'b00, 32'h05, 2'b00, 1'b1, 1'b0, 22'h0, 8'h00, 2, 34'h8, 34'h101C};
    vecs[13] = '{"l0_xw",    1'b1, {10'd2, 10'd7}, 32'h0000_0401, 2'b00, 32'h0D, 2'b00, 1'b1, 1'b0, 22'h0, 8'h00, 2, 34'h8, 34'h101C};
    vecs[14] = '{"l0_ptr",   1'b1, {10'd2, 10'd7}, 32'h0000_0401, 2'b00, 32'h01, 2'b00, 1'b1, 1'b0, 22'h0, 8'h00, 2, 34'h8, 34'h101C};
    vecs[15] = '{"two_lvl",  1'b1, {10'd2, 10'd7}, 32'h0000_0401, 2'b00, {22'h012345, 2'b00, 8'hCF}, 2'b00, 1'b0, 1'b0, 22'h012345, 8'hCF, 2, 34'h8, 34'h101C};
    vecs[16] = '{"bare",     1'b0, 20'hABCDE,      32'h0,         2'b00, 32'h0, 2'b00, 1'b0, 1'b0, 22'h0ABCDE, 8'hCF, 0, 34'h0, 34'h0};

    foreach (vecs[i]) begin
      vec_t v;
      bit e_pf;
      logic [21:0] e_ppn;
      logic [7:0] e_bits;
      v = vecs[i];
      e_pf = v.pf;
      e_ppn = v.ppn;
      e_bits = v.bits;
      if (AD_CHECK && v.mode && !v.pf && !v.af && !v.bits[6]) begin
        e_pf = 1'b1;
        e_ppn = 22'h0;
        e_bits = 8'h0;
      end
      mem.delete();
      mem[longint'(v.vpn[19:10])] = {v.rsp1, v.pte1};
      mem[longint'(v.pte1[31:10]) * 1024 + longint'(v.vpn[9:0])] = {v.rsp0, v.pte0};
      run_walk(v.name, v.mode, 22'h0, v.vpn, 0, e_pf, v.af, e_ppn, e_bits, v.nreads, v.a1, v.a2);
    end

    // Three waitrequest cycles on the first read: address must not move.
    mem.delete();
    mem[3] = {2'b00, 32'h0010_004F};
    run_walk("stall3", 1'b1, 22'h0, {10'd3, 10'd5}, 3, 1'b0, 1'b0, 22'h000405, 8'h4F, 1, 34'hC, 34'h0);
    chk("stall3.cycles", 64'(stall_addrs.size()), 64'd3);
    foreach (stall_addrs[i]) chk($sformatf("stall3.addr%0d", i), 64'(stall_addrs[i]), 64'hC);

    // Reset while the read is stalled: the strobe must drop without waiting for a clock.
    start_walk(1'b1, 22'h0, {10'd3, 10'd5}, 5);
    resolve_request = 1'b0;
    #2 async_rst = 1'b1;
    #1;
    chk("rst_issue.avl_read", 64'(avl_read), 64'd0);
    chk("rst_issue.avl_address", 64'(avl_address), 64'd0);
    chk("rst_issue.state", 64'(state_debug_output[1:0]), 64'd0);
    #1 async_rst = 1'b0;
    stall_left = 0;

    // Reset while waiting for data; the data beat then lands on an idle walker.
    start_walk(1'b1, 22'h0, {10'd3, 10'd5}, 0);
    resolve_request = 1'b0;
    @(posedge clk);
    #3 async_rst = 1'b1;
    #1;
    chk("rst_wait.state", 64'(state_debug_output[1:0]), 64'd0);
    #1 async_rst = 1'b0;
    done_count = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (resolve_done) done_count++;
    end
    chk("rst_wait.no_done", 64'(done_count), 64'd0);
    chk("rst_wait.ppn", 64'(resolve_physical_address), 64'd0);
    chk("rst_wait.idle", 64'(state_debug_output[1:0]), 64'd0);

    for (int t = 0; t < 60; t++) begin
      bit mode;
      logic [21:0] root;
      logic [19:0] va;
      logic [31:0] p1, p0;
      logic [1:0] r1, r0;
      int stall;
      mode = ($urandom_range(0, 7) != 0);
      root = 22'($urandom);
      va = 20'($urandom);
      stall = $urandom_range(0, 3);
      p1 = rand_pte(1'b1);
      p0 = rand_pte(1'b0);
      r1 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r0 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      mem.delete();
      mem[longint'(root) * 1024 + longint'(va[19:10])] = {r1, p1};
      mem[longint'(p1[31:10]) * 1024 + longint'(va[9:0])] = {r0, p0};
      ref_walk(mode, longint'(root), longint'(va), m_pf, m_af, m_ppn, m_bits, m_n, m_a1, m_a2);
      run_walk($sformatf("rnd%0d", t), mode, root, va, stall, m_pf, m_af, 22'(m_ppn), 8'(m_bits), m_n, 34'(m_a1), 34'(m_a2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
